rijndael_mixkey_stage: RTL
==========================

// Module: rijndael_mixkey_stage
// PURPOSE
//  - Registered round-datapath stage directly downstream of rijndael_subbytes.
//  - Takes a SubBytes-output state and computes ShiftRows -> MixColumns -> AddRoundKey.
//  - Skips MixColumns on the final round.
//  - Ready/valid on both sides; one stage of the iterative Rijndael round pipeline.
// PARAMETERS
//  NB         4                   state columns (4..8); Rijndael block = 32*NB bits
//  STATESIZE  32*NB (localparam)  state/key width
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst_n         in   1          asynchronous active-low reset
//  flush         in   1          synchronous discard of all held data
//  in_valid      in   1          upstream state valid
//  in_ready      out  1          stage can accept
//  in_state      in   STATESIZE  SubBytes output
//  in_round_key  in   STATESIZE  round key for this round
//  in_last       in   1          final round: bypass MixColumns
//  out_valid     out  1          out_state valid
//  out_ready     in   1          downstream accepts
//  out_state     out  STATESIZE  round result
// BEHAVIOUR
//  - Byte order: byte k = state[STATESIZE-1-8k -: 8]; column c = bytes 4c..4c+3; row r = byte 4c+r.
//  - ShiftRows: out[r][c] = in[r][(c+s_r) mod NB].
//    - s = {0,1,2,3} for NB<=6; {0,1,2,4} for NB=7; {0,1,3,4} for NB=8.
//  - MixColumns per column, GF(2^8) matrix rows [2 3 1 1],[1 2 3 1],[1 1 2 3],[3 1 1 2].
//    - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
//  - Result = (in_last ? SR(in) : MC(SR(in))) ^ in_round_key. All math is pure XOR; no width growth.
//  - Accept: rising edge with in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Latency: exactly 1 cycle from accept to out_valid=1 when the stage is empty.
//  - out_state and out_valid stay stable while out_valid && !out_ready.
//  - Accepts are never dropped; ordering is preserved.
//  - Reset (async, rst_n=0): out_valid=0, out_state=0, all internal valid bits 0.
//    - in_ready=1 once rst_n=1; reset mid-transfer discards everything.
//  - flush=1: at the next edge all valid bits clear and out_state is left unchanged.
//    - Any same-cycle input is discarded; flush has priority over accept and over transfer.
//  - Simultaneous accept + transfer while full (main register) refills main in the same edge.
//    - Full throughput; no bubble.
//  - Inputs are sampled only on accept; in_state, in_round_key and in_last are don't-care otherwise.
// CONFIGURATION
//  - RIJNDAEL_SKID_EN defined: 2-entry skid buffer (main + skid register).
//    - in_ready is a registered signal, = !skid_valid.
//    - Accept while main is held and !out_ready writes skid.
//    - On out_ready with skid valid, skid moves to main and skid_valid clears.
//    - No combinational in_ready <- out_ready path.
//  - RIJNDAEL_SKID_EN undefined: single main register.
//    - in_ready = !out_valid || out_ready (combinational).
//    - Same latency and throughput.
// TESTING
//  - NB=4, in_state=d42711aee0bf98f1b8b45de51e415230, key=a0fafe1788542cb123a339392a6c7605, in_last=0
//    -> next cycle out_valid=1, out_state=a49c7ff2689f352b6b5bea43026a5049.
//  - NB=4, in_state=000102030405060708090a0b0c0d0e0f, key=0, in_last=1
//    -> out_state=00050a0f04090e03080d02070c01060b.
//  - NB=8, in_last=1, key=0, in_state bytes 00..1f
//    -> row1 shifted by 1, row2 by 3, row3 by 4; column 0 = 00 05 0e 13.
//  - out_ready=0 for 5 cycles while 3 states are offered:
//    - skid build: 2 accepted, then in_ready=0;
//    - non-skid build: 1 accepted, then in_ready=0;
//    - after release, all outputs appear in order with no loss or duplication.
//  - Back-to-back stream of 16 states with out_ready=1 -> one result per cycle, 1-cycle latency.
//  - rst_n pulled low while out_valid=1 and stalled -> out_valid=0, out_state=0 immediately.
//    - Flush with simultaneous in_valid -> next cycle out_valid=0, input not delivered.

Source files
------------

// File: rtl/rijndael_mixkey_stage.sv
// Rijndael round stage: ShiftRows -> MixColumns (skipped on final round) -> AddRoundKey, registered.
// Define RIJNDAEL_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module rijndael_mixkey_stage #(
  parameter  int NB        = 4,
  localparam int STATESIZE = 32 * NB
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [STATESIZE-1:0] in_state,
  input  logic [STATESIZE-1:0] in_round_key,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATESIZE-1:0] out_state
);

  function automatic int unsigned shift_of(input int unsigned r);
    if (NB == 8 && r == 2) return 3;
    if (NB >= 7 && r == 3) return 4;
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  logic [STATESIZE-1:0] sr_state;
  logic [STATESIZE-1:0] mc_state;
  logic [STATESIZE-1:0] result;

  always_comb begin
    sr_state = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr_state[STATESIZE-1-8*(4*c+r) -: 8] =
          in_state[STATESIZE-1-8*(4*((c + shift_of(r)) % NB)+r) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3, x0, x1, x2, x3;
    mc_state = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      a0 = sr_state[STATESIZE-1-8*(4*c+0) -: 8];
      a1 = sr_state[STATESIZE-1-8*(4*c+1) -: 8];
      a2 = sr_state[STATESIZE-1-8*(4*c+2) -: 8];
      a3 = sr_state[STATESIZE-1-8*(4*c+3) -: 8];
      x0 = xtime(a0);
      x1 = xtime(a1);
      x2 = xtime(a2);
      x3 = xtime(a3);
      mc_state[STATESIZE-1-8*(4*c+0) -: 8] = x0 ^ x1 ^ a1 ^ a2 ^ a3;
      mc_state[STATESIZE-1-8*(4*c+1) -: 8] = a0 ^ x1 ^ x2 ^ a2 ^ a3;
      mc_state[STATESIZE-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ x2 ^ x3 ^ a3;
      mc_state[STATESIZE-1-8*(4*c+3) -: 8] = x0 ^ a0 ^ a1 ^ a2 ^ x3;
    end
  end

  assign result = (in_last ? sr_state : mc_state) ^ in_round_key;

`ifdef RIJNDAEL_SKID_EN
  logic                 skid_valid;
  logic [STATESIZE-1:0] skid_state;

  // in_ready comes straight from a flop, so there is no out_ready -> in_ready path.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_state  <= '0;
      skid_valid <= 1'b0;
      skid_state <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_valid && !out_ready) begin
      if (in_valid && in_ready) begin
        skid_state <= result;
        skid_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      out_state  <= skid_state;
      skid_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_state <= result;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_state <= result;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
